iir_coef_loader: RTL and testbench

Coefficient programming front-end for the biquad IIR filter. It accepts host register writes into a shadow bank and checks the staged denominator for stability. Accepted sets are committed atomically to the active bank only on a sample boundary, so the filter never computes one sample with a mix of old and new coefficients. The active outputs drive the filter's b0/b1/b2/a1/a2 inputs directly, and an optional flush pulse clears the filter's delay-line history on each update.

---
 rtl/iir_coef_loader.sv | 202 ++++++++++++++++++++
 tb/tb_iir_coef_loader.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_coef_loader.sv
// iir_coef_loader: shadow/active coefficient banks for the biquad IIR.
// Staged sets are stability-checked and applied atomically on sample_tick.
module iir_coef_loader #(
  parameter int W              = 16,
  parameter bit FLUSH_ON_APPLY = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wr_en,
  input  logic [2:0]   i_wr_addr,
  input  logic [W-1:0] i_wr_data,
  input  logic         i_commit,
  input  logic         i_sample_tick,
  input  logic [2:0]   i_rd_addr,
  output logic [W-1:0] o_rd_data,
  output logic [W-1:0] o_b0,
  output logic [W-1:0] o_b1,
  output logic [W-1:0] o_b2,
  output logic [W-1:0] o_a1,
  output logic [W-1:0] o_a2,
  output logic         o_pending,
  output logic         o_err,
  output logic         o_flush
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ARMED
  } state_t;

  localparam logic [W-1:0] B0_RST =
    {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] NEG_ONE =
    {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W+1:0] ONE_X =
    {3'b001, {(W-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [W-1:0] r_sh_b0;
  logic [W-1:0] r_sh_b1;
  logic [W-1:0] r_sh_b2;
  logic [W-1:0] r_sh_a1;
  logic [W-1:0] r_sh_a2;

  logic [W-1:0] r_b0;
  logic [W-1:0] r_b1;
  logic [W-1:0] r_b2;
  logic [W-1:0] r_a1;
  logic [W-1:0] r_a2;

  logic [W-1:0] r_rd_data;
  logic [W-1:0] w_rd_data;
  logic         r_err;
  logic         r_flush;

  logic         w_addr_ok;
  logic         w_sh_we;
  logic         w_bad;
  logic         w_fail;
  logic         w_apply;

  logic signed [W+1:0] w_a1x;
  logic signed [W+1:0] w_a2x;
  logic signed [W+1:0] w_abs_a1;
  logic signed [W+1:0] w_lim;
  logic                w_a2_ok;
  logic                w_stable;

  assign w_addr_ok = (i_wr_addr < 3'd5);

  // |a1| < 1 + a2, widened so -1.0 and 1+a2 both fit
  assign w_a1x    = {{2{r_sh_a1[W-1]}}, r_sh_a1};
  assign w_a2x    = {{2{r_sh_a2[W-1]}}, r_sh_a2};
  assign w_abs_a1 = w_a1x[W+1] ? -w_a1x : w_a1x;
  assign w_lim    = ONE_X + w_a2x;
  assign w_a2_ok  = (r_sh_a2 != NEG_ONE);
  assign w_stable = w_a2_ok && (w_abs_a1 < w_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_commit) w_next = S_CHECK;
      end
      S_CHECK: begin
        w_next = w_stable ? S_ARMED : S_IDLE;
      end
      S_ARMED: begin
        if (i_sample_tick) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sh_we = 1'b0;
    w_bad   = 1'b0;
    w_fail  = 1'b0;
    w_apply = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_sh_we = i_wr_en && w_addr_ok;
        w_bad   = i_wr_en && !w_addr_ok;
      end
      S_CHECK: begin
        w_fail = !w_stable;
        w_bad  = i_wr_en || i_commit;
      end
      S_ARMED: begin
        w_apply = i_sample_tick;
        w_bad   = i_wr_en || i_commit;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh_b0 <= B0_RST;
      r_sh_b1 <= '0;
      r_sh_b2 <= '0;
      r_sh_a1 <= '0;
      r_sh_a2 <= '0;
    end else if (w_sh_we) begin
      case (i_wr_addr)
        3'd0:    r_sh_b0 <= i_wr_data;
        3'd1:    r_sh_b1 <= i_wr_data;
        3'd2:    r_sh_b2 <= i_wr_data;
        3'd3:    r_sh_a1 <= i_wr_data;
        3'd4:    r_sh_a2 <= i_wr_data;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_b0 <= B0_RST;
      r_b1 <= '0;
      r_b2 <= '0;
      r_a1 <= '0;
      r_a2 <= '0;
    end else if (w_apply) begin
      r_b0 <= r_sh_b0;
      r_b1 <= r_sh_b1;
      r_b2 <= r_sh_b2;
      r_a1 <= r_sh_a1;
      r_a2 <= r_sh_a2;
    end
  end

  always_comb begin
    w_rd_data = '0;
    case (i_rd_addr)
      3'd0:    w_rd_data = r_b0;
      3'd1:    w_rd_data = r_b1;
      3'd2:    w_rd_data = r_b2;
      3'd3:    w_rd_data = r_a1;
      3'd4:    w_rd_data = r_a2;
      default: w_rd_data = '0;
    endcase
  end

  // a dropped request in the apply cycle still leaves err set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err     <= 1'b0;
      r_flush   <= 1'b0;
      r_rd_data <= '0;
    end else begin
      if (w_bad || w_fail) begin
        r_err <= 1'b1;
      end else if (w_apply) begin
        r_err <= 1'b0;
      end
      r_flush   <= w_apply && FLUSH_ON_APPLY;
      r_rd_data <= w_rd_data;
    end
  end

  assign o_b0      = r_b0;
  assign o_b1      = r_b1;
  assign o_b2      = r_b2;
  assign o_a1      = r_a1;
  assign o_a2      = r_a2;
  assign o_rd_data = r_rd_data;
  assign o_pending = (r_state == S_ARMED);
  assign o_err     = r_err;
  assign o_flush   = r_flush;

endmodule

// File: tb/tb_iir_coef_loader.sv
// tb_iir_coef_loader: scoreboard bench for the coefficient loader.
// Applied sets are queued at the tick and checked when flush fires.
module tb_iir_coef_loader;

  localparam logic [4:0][15:0] RST_SET =
    {16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_wr_en = 1'b0;
  logic [2:0]  i_wr_addr = '0;
  logic [15:0] i_wr_data = '0;
  logic        i_commit = 1'b0;
  logic        i_sample_tick = 1'b0;
  logic [2:0]  i_rd_addr = '0;

  logic [15:0] o_rd_data;
  logic [15:0] o_b0, o_b1, o_b2, o_a1, o_a2;
  logic        o_pending, o_err, o_flush;

  logic [15:0] n_rd_data;
  logic [15:0] n_b0, n_b1, n_b2, n_a1, n_a2;
  logic        n_pending, n_err, n_flush;

  logic [4:0][15:0] w_act;
  assign w_act = {o_a2, o_a1, o_b2, o_b1, o_b0};

  logic [4:0][15:0] e_sh;
  logic [4:0][15:0] e_act;
  logic             e_err;
  logic [4:0][15:0] set_q[$];

  int nvec = 0;
  int nerr = 0;
  int napply = 0;
  int nflush = 0;
  int nflush_n = 0;

  always #5 clk = ~clk;

  iir_coef_loader #(.W(16), .FLUSH_ON_APPLY(1'b1)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_commit(i_commit),
    .i_sample_tick(i_sample_tick), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data),
    .o_b0(o_b0), .o_b1(o_b1), .o_b2(o_b2),
    .o_a1(o_a1), .o_a2(o_a2),
    .o_pending(o_pending), .o_err(o_err), .o_flush(o_flush)
  );

  iir_coef_loader #(.W(16), .FLUSH_ON_APPLY(1'b0)) dut_nf (
    .clk(clk), .rst(rst),
    .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_commit(i_commit),
    .i_sample_tick(i_sample_tick), .i_rd_addr(i_rd_addr),
    .o_rd_data(n_rd_data),
    .o_b0(n_b0), .o_b1(n_b1), .o_b2(n_b2),
    .o_a1(n_a1), .o_a2(n_a2),
    .o_pending(n_pending), .o_err(n_err), .o_flush(n_flush)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (n_flush) nflush_n++;
      if (o_flush) begin
        nflush++;
        nvec++;
        if (set_q.size() == 0) begin
          nerr++;
          $display("FAIL sb_unexpected_flush act=%h", w_act);
        end else if (w_act !== set_q[0]) begin
          nerr++;
          $display("FAIL sb_apply act=%h exp=%h",
                   w_act, set_q[0]);
          void'(set_q.pop_front());
        end else begin
          void'(set_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout nvec=%0d", nvec);
    $fatal(1, "timeout");
  end

  function automatic bit stab(logic [15:0] a1,
                              logic [15:0] a2);
    int s1, s2, m;
    s1 = $signed(a1);
    s2 = $signed(a2);
    m = (s1 < 0) ? -s1 : s1;
    return (s2 != -32768) && (m < 32768 + s2);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [15:0] d);
    i_wr_en = 1'b1;
    i_wr_addr = a;
    i_wr_data = d;
    cyc();
    i_wr_en = 1'b0;
    if (a < 3'd5) e_sh[a] = d;
    else e_err = 1'b1;
  endtask

  task automatic do_commit(input bit with_wr,
                           input logic [2:0] a,
                           input logic [15:0] d);
    bit pass;
    i_commit = 1'b1;
    i_wr_en = with_wr;
    i_wr_addr = a;
    i_wr_data = d;
    cyc();
    i_commit = 1'b0;
    i_wr_en = 1'b0;
    if (with_wr) e_sh[a] = d;
    pass = stab(e_sh[3], e_sh[4]);
    nvec++;
    if (o_pending !== 1'b0) begin
      nerr++;
      $display("FAIL check_pending act=%b exp=0", o_pending);
    end
    cyc();
    if (!pass) e_err = 1'b1;
    nvec++;
    if (o_pending !== pass || o_err !== e_err) begin
      nerr++;
      $display("FAIL commit_result pend=%b err=%b exp=%b/%b",
               o_pending, o_err, pass, e_err);
    end
    nvec++;
    if (w_act !== e_act) begin
      nerr++;
      $display("FAIL commit_hold act=%h exp=%h", w_act, e_act);
    end
  endtask

  task automatic do_apply();
    set_q.push_back(e_sh);
    i_sample_tick = 1'b1;
    cyc();
    i_sample_tick = 1'b0;
    e_act = e_sh;
    e_err = 1'b0;
    napply++;
    nvec++;
    if (o_pending !== 1'b0 || o_flush !== 1'b1 ||
        o_err !== e_err) begin
      nerr++;
      $display("FAIL apply pend=%b flush=%b err=%b exp=0/1/%b",
               o_pending, o_flush, o_err, e_err);
    end
    cyc();
    nvec++;
    if (o_flush !== 1'b0) begin
      nerr++;
      $display("FAIL flush_width act=%b exp=0", o_flush);
    end
  endtask

  task automatic test_reset_defaults();
    nvec++;
    if (w_act !== RST_SET || o_pending !== 1'b0 ||
        o_err !== 1'b0 || o_flush !== 1'b0) begin
      nerr++;
      $display("FAIL reset_defaults act=%h p=%b e=%b f=%b",
               w_act, o_pending, o_err, o_flush);
    end
  endtask

  task automatic test_normal_load();
    wr(3'd0, 16'h2000);
    wr(3'd1, 16'h4000);
    wr(3'd2, 16'h2000);
    wr(3'd3, 16'hC000);
    wr(3'd4, 16'h1000);
    do_commit(1'b0, 3'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      nvec++;
      if (o_pending !== 1'b1 || w_act !== e_act) begin
        nerr++;
        $display("FAIL normal_wait%0d p=%b act=%h exp=%h",
                 i, o_pending, w_act, e_act);
      end
    end
    do_apply();
    for (int a = 0; a < 5; a++) begin
      i_rd_addr = 3'(a);
      cyc();
      nvec++;
      if (o_rd_data !== e_act[a]) begin
        nerr++;
        $display("FAIL readback%0d act=%h exp=%h",
                 a, o_rd_data, e_act[a]);
      end
    end
  endtask

  task automatic test_reset_midrun();
    wr(3'd6, 16'h1234);
    wr(3'd0, 16'h1111);
    do_commit(1'b0, 3'd0, 16'h0);
    rst = 1'b1;
    #1;
    nvec++;
    if (w_act !== RST_SET || o_pending !== 1'b0 ||
        o_err !== 1'b0 || o_flush !== 1'b0 ||
        o_rd_data !== 16'h0) begin
      nerr++;
      $display("FAIL reset_async act=%h p=%b e=%b f=%b rd=%h",
               w_act, o_pending, o_err, o_flush, o_rd_data);
    end
    @(negedge clk);
    rst = 1'b0;
    e_sh = RST_SET;
    e_act = RST_SET;
    e_err = 1'b0;
    i_rd_addr = 3'd0;
    cyc();
    nvec++;
    if (o_rd_data !== 16'h7FFF) begin
      nerr++;
      $display("FAIL reset_rd act=%h exp=7fff", o_rd_data);
    end
    i_sample_tick = 1'b1;
    cyc();
    i_sample_tick = 1'b0;
    nvec++;
    if (o_flush !== 1'b0 || w_act !== RST_SET) begin
      nerr++;
      $display("FAIL reset_discard f=%b act=%h", o_flush, w_act);
    end
  endtask

  task automatic test_unstable();
    wr(3'd3, 16'h8000);
    wr(3'd4, 16'h0000);
    do_commit(1'b0, 3'd0, 16'h0);
    wr(3'd3, 16'hC000);
    do_commit(1'b0, 3'd0, 16'h0);
    do_apply();
  endtask

  task automatic test_boundary();
    wr(3'd3, 16'h0000);
    wr(3'd4, 16'h8000);
    do_commit(1'b0, 3'd0, 16'h0);
    wr(3'd3, 16'h7FFF);
    wr(3'd4, 16'h7FFF);
    do_commit(1'b0, 3'd0, 16'h0);
    do_apply();
  endtask

  task automatic test_collide();
    do_commit(1'b1, 3'd4, 16'h8000);
    do_commit(1'b1, 3'd4, 16'h1000);
    i_wr_en = 1'b1;
    i_wr_addr = 3'd0;
    i_wr_data = 16'h1234;
    cyc();
    i_wr_en = 1'b0;
    e_err = 1'b1;
    nvec++;
    if (o_err !== 1'b1 || o_pending !== 1'b1) begin
      nerr++;
      $display("FAIL armed_drop err=%b p=%b exp=1/1",
               o_err, o_pending);
    end
    do_apply();
  endtask

  task automatic test_tick_in_check();
    wr(3'd0, 16'h0ABC);
    i_commit = 1'b1;
    cyc();
    i_commit = 1'b0;
    i_sample_tick = 1'b1;
    cyc();
    i_sample_tick = 1'b0;
    repeat (2) begin
      cyc();
      nvec++;
      if (o_pending !== 1'b1 || o_flush !== 1'b0 ||
          w_act !== e_act) begin
        nerr++;
        $display("FAIL tick_in_check p=%b f=%b act=%h exp=%h",
                 o_pending, o_flush, w_act, e_act);
      end
    end
    do_apply();
  endtask

  task automatic test_invalid();
    wr(3'd6, 16'h5555);
    nvec++;
    if (o_err !== 1'b1) begin
      nerr++;
      $display("FAIL invalid_err act=%b exp=1", o_err);
    end
    for (int a = 5; a < 8; a++) begin
      i_rd_addr = 3'(a);
      cyc();
      nvec++;
      if (o_rd_data !== 16'h0) begin
        nerr++;
        $display("FAIL invalid_rd%0d act=%h exp=0",
                 a, o_rd_data);
      end
    end
    do_commit(1'b0, 3'd0, 16'h0);
    do_apply();
  endtask

  initial begin
    e_sh = RST_SET;
    e_act = RST_SET;
    e_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    test_reset_defaults();
    test_normal_load();
    test_reset_midrun();
    test_unstable();
    test_boundary();
    test_collide();
    test_tick_in_check();
    test_invalid();
    repeat (2) cyc();
    nvec++;
    if (set_q.size() != 0 || nflush != napply) begin
      nerr++;
      $display("FAIL sb_drain left=%0d flush=%0d exp=%0d",
               set_q.size(), nflush, napply);
    end
    nvec++;
    if (nflush_n != 0 || {n_a2, n_a1, n_b2, n_b1, n_b0}
        !== e_act) begin
      nerr++;
      $display("FAIL noflush_inst flush=%0d act=%h exp=%h",
               nflush_n, {n_a2, n_a1, n_b2, n_b1, n_b0},
               e_act);
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
